sample_stream_bridge: RTL and testbench
=======================================

// Module: sample_stream_bridge
// PURPOSE
//  Multi-channel successor to the single-counter sample FIFO/MBED path. On each sample tick it
//  snapshots NCH channel samples and queues them as channel-tagged words in an internal FIFO.
//  On each MCU ready edge it hands a burst of up to BURST words to the existing SPI master.
//  Sits between the ADC front-end and the SPI master that feeds the MBED.
// PARAMETERS
//  NCH       4    channels captured per tick (1..2**CHB)
//  DW        16   sample width per channel
//  CHB       2    channel-tag width; output word OW = CHB+DW, tag in [OW-1:DW]
//  ABITS     10   FIFO address bits; depth = 2**ABITS words
//  TICK_DIV  128  internal tick period in SYS_CLK cycles (>= NCH+1)
//  BURST     16   max words sent per ready edge (1..2**ABITS)
// PORTS
//  SYS_CLK   in   1       system clock (40 MHz)
//  RSTbar    in   1       asynchronous active-low reset
//  EN        in   1       capture enable; 0 = no ticks accepted
//  TICK_SEL  in   1       0 = internal divider tick, 1 = EXT_TICK
//  EXT_TICK  in   1       external one-cycle tick pulse, SYS_CLK domain
//  CH_DATA   in   NCH*DW  channel samples, ch k at [k*DW +: DW]
//  MBED_RDY  in   1       MCU ready level, asynchronous
//  SPI_FIN   in   1       one-cycle pulse from SPI master: word done
//  SPI_ENA   out  1       request SPI master to send SPI_DATA
//  SPI_DATA  out  OW      FIFO head word (first-word-fall-through)
//  FILL      out  ABITS+1 FIFO occupancy
//  EMPTY     out  1       FIFO empty
//  FULL      out  1       FIFO full
//  OVF       out  1       sticky: at least one frame dropped
//  DROP_CNT  out  16      dropped-frame count, saturates at 16'hFFFF
//  BUSY      out  1       read burst in progress
// BEHAVIOUR
//  Reset (async, RSTbar=0): FIFO flushed, divider=0, both FSMs idle. SPI_ENA=0, SPI_DATA=0,
//   FILL=0, EMPTY=1, FULL=0, OVF=0, DROP_CNT=0, BUSY=0. Deassertion mid-burst aborts the burst.
//  Tick: internal divider counts 0..TICK_DIV-1 and pulses at wrap. It free-runs regardless of EN.
//   A tick counts only when EN=1.
//  Write FSM W_IDLE/W_FILL: on a tick in W_IDLE, latch all CH_DATA into a snapshot register.
//   If free slots >= NCH, go to W_FILL and write ch0..ch(NCH-1), one per cycle.
//   The first write is on the cycle after the tick; word = {ch_index, sample}.
//   If free slots < NCH, drop the whole frame (no partial frames), set OVF, increment DROP_CNT.
//   A tick arriving while in W_FILL is also a dropped frame.
//  Read path: MBED_RDY passes through a 2-FF synchroniser; a rising edge is detected on the
//   synchronised level.
//  Read FSM R_IDLE/R_SEND/R_GAP:
//   R_IDLE: rising edge with EMPTY=0 -> R_SEND, burst count=0, BUSY=1.
//    A rising edge with EMPTY=1 is ignored.
//   R_SEND: SPI_ENA=1, SPI_DATA stable. On SPI_FIN: pop the head word the same cycle,
//    increment the count, go to R_GAP.
//   R_GAP: SPI_ENA=0 for one cycle. Return to R_IDLE (BUSY=0) if count==BURST or FIFO is
//    empty; otherwise go to R_SEND.
//   Rising edges during a burst are ignored. SPI_FIN outside R_SEND is ignored.
//  FIFO: a write and a pop in the same cycle are both honoured, and FILL is unchanged.
//   A write while FULL cannot occur, because the frame-space check guarantees room.
//   Pointers wrap modulo 2**ABITS. FILL is exact, 0..2**ABITS.
//  SPI_DATA shows the head word whenever EMPTY=0. Latency from write to SPI_DATA is 1 cycle.
// STRUCTURE
//  Shared header stream_defs.vh: OW width macro, write-FSM and read-FSM state encodings,
//   DROP_CNT width.
//  Sub-module sync_fifo_fwft (ABITS, OW): single-clock FWFT FIFO with FILL/EMPTY/FULL outputs.
//  Top level holds the tick divider, snapshot register, both FSMs and the synchroniser.
// TESTING
//  Reset mid-burst: RSTbar low during R_SEND -> SPI_ENA=0 immediately; FILL=0, OVF=0 after release.
//  NCH=4, DW=16, TICK_SEL=1, one EXT_TICK, CH_DATA={16'h0004,16'h0003,16'h0002,16'h0001}
//   -> words 18'h00001, 18'h10002, 18'h20003, 18'h30004 on cycles t+1..t+4; FILL=4.
//  Burst: FILL=20, BURST=16, MBED_RDY rise, SPI_FIN 8 cycles after each SPI_ENA
//   -> exactly 16 words in FIFO order, BUSY falls, FILL=4.
//  Early stop: FILL=3, BURST=16, MBED_RDY rise -> 3 words sent, then R_IDLE with EMPTY=1.
//   A second MBED_RDY rise sends nothing.
//  Overflow: ABITS=3 (depth 8), FILL=6, tick -> frame dropped, FILL stays 6, OVF=1, DROP_CNT=1.
//   A tick with FILL=4 is accepted (FILL=8, FULL=1).
//  Concurrency: tick coincident with a pop, plus an EXT_TICK during W_FILL
//   -> FILL correct, DROP_CNT+1, no word lost or duplicated.
//   Internal-divider tick spacing = 128 cycles.

Source files
------------

// File: rtl/sample_stream_bridge_pkg.sv
// Shared types and constants for the sample stream bridge: FSM encodings and
// drop-counter width.
package sample_stream_bridge_pkg;

  localparam int DROP_W = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef enum logic {
    W_IDLE,
    W_FILL
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_SEND,
    R_GAP
  } rd_state_t;

endpackage

// File: rtl/sample_stream_bridge_fifo.sv
// Single-clock first-word-fall-through FIFO with exact occupancy; the head word
// is visible on rd_data the cycle after it is written, and rd_data is 0 when empty.
module sync_fifo_fwft #(
  parameter int ABITS = 10,
  parameter int OW    = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [OW-1:0]    wr_data,
  input  logic             rd_en,
  output logic [OW-1:0]    rd_data,
  output logic [ABITS:0]   fill,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 2 ** ABITS;

  logic [OW-1:0]    mem [DEPTH];
  logic [ABITS-1:0] wr_ptr;
  logic [ABITS-1:0] rd_ptr;
  logic [ABITS:0]   fill_q;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // NOTE: the storage array is deliberately left out of reset; only pointers and
  // occupancy define validity, so resetting the array would just cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so a simultaneous write and pop both see the same old fill_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + ABITS'(1);
      if (do_rd) rd_ptr <= rd_ptr + ABITS'(1);
      fill_q <= fill_q + (ABITS+1)'(do_wr) - (ABITS+1)'(do_rd);
    end
  end

  assign fill    = fill_q;
  assign empty   = (fill_q == '0);
  assign full    = (fill_q == (ABITS+1)'(DEPTH));
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sample_stream_bridge.sv
// Multi-channel sample bridge: snapshots NCH channels per tick into a tagged-word
// FIFO and hands bursts of up to BURST words to the SPI master on MCU ready edges.
module sample_stream_bridge
  import sample_stream_bridge_pkg::*;
#(
  parameter  int NCH      = 4,
  parameter  int DW       = 16,
  parameter  int CHB      = 2,
  parameter  int ABITS    = 10,
  parameter  int TICK_DIV = 128,
  parameter  int BURST    = 16,
  localparam int OW       = CHB + DW
) (
  input  logic              SYS_CLK,
  input  logic              RSTbar,
  input  logic              EN,
  input  logic              TICK_SEL,
  input  logic              EXT_TICK,
  input  logic [NCH*DW-1:0] CH_DATA,
  input  logic              MBED_RDY,
  input  logic              SPI_FIN,
  output logic              SPI_ENA,
  output logic [OW-1:0]     SPI_DATA,
  output logic [ABITS:0]    FILL,
  output logic              EMPTY,
  output logic              FULL,
  output logic              OVF,
  output logic [DROP_W-1:0] DROP_CNT,
  output logic              BUSY
);

  localparam int DEPTH = 2 ** ABITS;
  localparam int DIVW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BCW   = ABITS + 1;
  localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(TICK_DIV - 1);
  localparam logic [CHB-1:0]  LAST_CH    = CHB'(NCH - 1);
  localparam logic [BCW-1:0]  BURST_LAST = BCW'(BURST);

  logic [DIVW-1:0]   div_cnt;
  logic              int_tick;
  logic              tick;

  wr_state_t         w_state, w_next;
  logic [CHB-1:0]    ch_idx;
  logic [NCH*DW-1:0] snap;
  logic              frame_fits;
  logic              frame_start;
  logic              frame_drop;
  logic              wr_en;
  logic [OW-1:0]     wr_data;
  logic [ABITS:0]    free_slots;

  logic              rdy_meta, rdy_sync, rdy_prev;
  logic              rdy_rise;
  rd_state_t         r_state, r_next;
  logic [BCW-1:0]    burst_cnt;
  logic              rd_en;

  // Divider free-runs so the tick grid is unaffected by toggling EN.
  assign int_tick = (div_cnt == DIV_LAST);
  assign tick     = EN && (TICK_SEL ? EXT_TICK : int_tick);

  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar)       div_cnt <= '0;
    else if (int_tick) div_cnt <= '0;
    else               div_cnt <= div_cnt + DIVW'(1);
  end

  // Space is checked once per frame; pops during the frame only add room.
  assign free_slots = (ABITS+1)'(DEPTH) - FILL;
  assign frame_fits = (free_slots >= (ABITS+1)'(NCH));
  assign wr_data    = {ch_idx, snap[int'(ch_idx)*DW +: DW]};

  // NOTE: every always_comb output gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next      = w_state;
    wr_en       = 1'b0;
    frame_start = 1'b0;
    frame_drop  = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (tick) begin
          if (frame_fits) begin
            w_next      = W_FILL;
            frame_start = 1'b1;
          end else begin
            frame_drop  = 1'b1;
          end
        end
      end
      W_FILL: begin
        wr_en      = 1'b1;
        frame_drop = tick;
        if (ch_idx == LAST_CH) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      w_state  <= W_IDLE;
      ch_idx   <= '0;
      snap     <= '0;
      OVF      <= 1'b0;
      DROP_CNT <= '0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && tick) snap <= CH_DATA;
      if (frame_start) ch_idx <= '0;
      else if (wr_en)  ch_idx <= ch_idx + CHB'(1);
      if (frame_drop) begin
        OVF <= 1'b1;
        if (DROP_CNT != DROP_MAX) DROP_CNT <= DROP_CNT + DROP_W'(1);
      end
    end
  end

  // MBED_RDY is asynchronous: two flops to resolve metastability, a third for edge detect.
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      rdy_meta <= 1'b0;
      rdy_sync <= 1'b0;
      rdy_prev <= 1'b0;
    end else begin
      rdy_meta <= MBED_RDY;
      rdy_sync <= rdy_meta;
      rdy_prev <= rdy_sync;
    end
  end

  assign rdy_rise = rdy_sync && !rdy_prev;

  always_comb begin
    r_next  = r_state;
    rd_en   = 1'b0;
    SPI_ENA = 1'b0;
    case (r_state)
      R_IDLE: if (rdy_rise && !EMPTY) r_next = R_SEND;
      R_SEND: begin
        SPI_ENA = 1'b1;
        if (SPI_FIN) begin
          rd_en  = 1'b1;
          r_next = R_GAP;
        end
      end
      R_GAP: r_next = (burst_cnt == BURST_LAST || EMPTY) ? R_IDLE : R_SEND;
      default: r_next = R_IDLE;
    endcase
  end

  assign BUSY = (r_state != R_IDLE);

  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      r_state   <= R_IDLE;
      burst_cnt <= '0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE) burst_cnt <= '0;
      else if (rd_en)        burst_cnt <= burst_cnt + BCW'(1);
    end
  end

  sync_fifo_fwft #(
    .ABITS (ABITS),
    .OW    (OW)
  ) u_fifo (
    .clk     (SYS_CLK),
    .rst_n   (RSTbar),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (SPI_DATA),
    .fill    (FILL),
    .empty   (EMPTY),
    .full    (FULL)
  );

endmodule

// File: tb/tb_sample_stream_bridge.sv
// Scoreboard bench for sample_stream_bridge: a 1024-deep instance for capture and
// burst behaviour, plus an 8-deep instance (BURST=2) for the overflow boundary.
module tb_sample_stream_bridge;

  localparam int NCH   = 4;
  localparam int ABITS = 10;
  localparam int DEPTH = 2 ** ABITS;

  logic        sys_clk = 1'b0;
  logic        rstbar  = 1'b0;
  logic        en = 1'b0, tick_sel = 1'b1, ext_tick = 1'b0;
  logic [63:0] ch_data = '0;
  logic        mbed_rdy = 1'b0, spi_fin = 1'b0;
  logic        spi_ena, empty, full, ovf, busy;
  logic [17:0] spi_data;
  logic [10:0] fill;
  logic [15:0] drop_cnt;

  logic        s_en = 1'b0, s_mbed_rdy = 1'b0, s_spi_fin = 1'b0;
  logic        s_spi_ena, s_empty, s_full, s_ovf, s_busy;
  logic [17:0] s_spi_data;
  logic [3:0]  s_fill;
  logic [15:0] s_drop_cnt;

  int          vectors     = 0;
  int          miscompares = 0;
  int          exp_drop    = 0;
  logic [17:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  sample_stream_bridge #(
    .NCH(4), .DW(16), .CHB(2), .ABITS(ABITS), .TICK_DIV(128), .BURST(16)
  ) dut (
    .SYS_CLK(sys_clk), .RSTbar(rstbar), .EN(en), .TICK_SEL(tick_sel),
    .EXT_TICK(ext_tick), .CH_DATA(ch_data), .MBED_RDY(mbed_rdy), .SPI_FIN(spi_fin),
    .SPI_ENA(spi_ena), .SPI_DATA(spi_data), .FILL(fill), .EMPTY(empty), .FULL(full),
    .OVF(ovf), .DROP_CNT(drop_cnt), .BUSY(busy)
  );

  sample_stream_bridge #(
    .NCH(4), .DW(16), .CHB(2), .ABITS(3), .TICK_DIV(128), .BURST(2)
  ) dut_small (
    .SYS_CLK(sys_clk), .RSTbar(rstbar), .EN(s_en), .TICK_SEL(tick_sel),
    .EXT_TICK(ext_tick), .CH_DATA(ch_data), .MBED_RDY(s_mbed_rdy), .SPI_FIN(s_spi_fin),
    .SPI_ENA(s_spi_ena), .SPI_DATA(s_spi_data), .FILL(s_fill), .EMPTY(s_empty), .FULL(s_full),
    .OVF(s_ovf), .DROP_CNT(s_drop_cnt), .BUSY(s_busy)
  );

  function automatic logic [17:0] mk_word(input logic [63:0] d, input int k);
    logic [15:0] s;
    logic [1:0]  tag;
    s   = d[k*16 +: 16];
    tag = 2'(k);
    return {tag, s};
  endfunction

  // One EXT_TICK pulse; the main-instance model is updated only when its EN is high.
  task automatic main_frame(input logic [63:0] d);
    bit accept;
    @(negedge sys_clk);
    accept   = en && ((DEPTH - exp_q.size()) >= NCH);
    ch_data  = d;
    ext_tick = 1'b1;
    @(negedge sys_clk);
    ext_tick = 1'b0;
    ch_data  = ~d;
    if (accept) for (int k = 0; k < NCH; k++) exp_q.push_back(mk_word(d, k));
    else if (en) exp_drop++;
    repeat (5) @(negedge sys_clk);
  endtask

  // Raises MBED_RDY and plays the SPI master; optionally injects an accepted tick on
  // word tick_word's SPI_FIN and a second (dropped) tick two cycles later.
  task automatic run_burst(input string name, input int exp_words, input int tick_word,
                           input logic [63:0] tick_data);
    int          sent, waited;
    bit          done, accept, ticked;
    logic [17:0] exp_w;
    sent = 0;
    @(negedge sys_clk);
    mbed_rdy = 1'b1;
    waited = 0;
    while (spi_ena !== 1'b1 && waited < 12) begin
      @(negedge sys_clk);
      waited++;
    end
    done = 1'b0;
    if (spi_ena !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_start: spi_ena=%b after %0d cycles, required 1", name, spi_ena, waited);
      done = 1'b1;
    end
    while (!done) begin
      repeat (8) @(negedge sys_clk);
      exp_w = (exp_q.size() > 0) ? exp_q[0] : 18'bx;
      vectors++;
      if (spi_ena !== 1'b1 || spi_data !== exp_w) begin
        miscompares++;
        $display("FAIL %s_word%0d: ena=%b data=%h, required ena=1 data=%h",
                 name, sent, spi_ena, spi_data, exp_w);
      end
      spi_fin = 1'b1;
      ticked  = (sent == tick_word);
      if (ticked) begin
        ext_tick = 1'b1;
        ch_data  = tick_data;
        accept   = (DEPTH - exp_q.size()) >= NCH;
        if (accept) for (int k = 0; k < NCH; k++) exp_q.push_back(mk_word(tick_data, k));
        else exp_drop++;
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      sent++;
      @(negedge sys_clk);
      spi_fin  = 1'b0;
      ext_tick = 1'b0;
      ch_data  = ~tick_data;
      vectors++;
      if (spi_ena !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_gap%0d: spi_ena=%b, required 0", name, sent, spi_ena);
      end
      @(negedge sys_clk);
      if (ticked) begin
        ext_tick = 1'b1;
        exp_drop++;
      end
      done = (busy === 1'b0);
      if (ticked) begin
        @(negedge sys_clk);
        ext_tick = 1'b0;
      end
      if (!done && sent > exp_words + 2) begin
        vectors++;
        miscompares++;
        $display("FAIL %s_overrun: sent=%0d, required %0d", name, sent, exp_words);
        done = 1'b1;
      end
    end
    vectors++;
    if (sent != exp_words) begin
      miscompares++;
      $display("FAIL %s_count: sent=%0d, required %0d", name, sent, exp_words);
    end
    mbed_rdy = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    rstbar = 1'b0;
    #3;
    vectors++;
    if ({spi_ena, spi_data, fill, empty, full, ovf, drop_cnt, busy} !==
        {1'b0, 18'h0, 11'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_main: ena=%b data=%h fill=%0d empty=%b full=%b ovf=%b drop=%0d busy=%b, required 0/0/0/1/0/0/0/0",
               spi_ena, spi_data, fill, empty, full, ovf, drop_cnt, busy);
    end
    vectors++;
    if ({s_spi_ena, s_fill, s_empty, s_ovf, s_busy} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_small: ena=%b fill=%0d empty=%b ovf=%b busy=%b, required 0/0/1/0/0",
               s_spi_ena, s_fill, s_empty, s_ovf, s_busy);
    end
    @(negedge sys_clk);
    rstbar = 1'b1;
    repeat (3) @(negedge sys_clk);
    vectors++;
    if ({spi_ena, fill, empty, busy} !== {1'b0, 11'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_release: ena=%b fill=%0d empty=%b busy=%b, required 0/0/1/0",
               spi_ena, fill, empty, busy);
    end
  endtask

  task automatic test_ext_tick();
    en       = 1'b1;
    tick_sel = 1'b1;
    @(negedge sys_clk);
    ch_data  = 64'h0004_0003_0002_0001;
    ext_tick = 1'b1;
    @(negedge sys_clk);
    ext_tick = 1'b0;
    ch_data  = 64'hdead_beef_cafe_f00d;
    vectors++;
    if (fill !== 11'd0) begin
      miscompares++;
      $display("FAIL ext_tick_t0: fill=%0d, required 0", fill);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge sys_clk);
      vectors++;
      if (fill !== 11'(k) || spi_data !== 18'h00001 || empty !== 1'b0) begin
        miscompares++;
        $display("FAIL ext_tick_t%0d: fill=%0d head=%h empty=%b, required fill=%0d head=00001 empty=0",
                 k, fill, spi_data, empty, k);
      end
    end
    exp_q.push_back(18'h00001);
    exp_q.push_back(18'h10002);
    exp_q.push_back(18'h20003);
    exp_q.push_back(18'h30004);
  endtask

  task automatic test_burst();
    for (int f = 0; f < 4; f++) main_frame({$urandom, $urandom});
    vectors++;
    if (fill !== 11'd20) begin
      miscompares++;
      $display("FAIL burst_prefill: fill=%0d, required 20", fill);
    end
    run_burst("burst", 16, -1, 64'h0);
    vectors++;
    if (busy !== 1'b0 || fill !== 11'd4) begin
      miscompares++;
      $display("FAIL burst_end: busy=%b fill=%0d, required busy=0 fill=4", busy, fill);
    end
  endtask

  task automatic test_early_stop();
    bit saw;
    run_burst("early", 4, -1, 64'h0);
    vectors++;
    if (empty !== 1'b1 || fill !== 11'd0) begin
      miscompares++;
      $display("FAIL early_empty: empty=%b fill=%0d, required empty=1 fill=0", empty, fill);
    end
    @(negedge sys_clk);
    mbed_rdy = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(negedge sys_clk);
      if (spi_ena !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    vectors++;
    if (saw !== 1'b0) begin
      miscompares++;
      $display("FAIL early_rise_on_empty: burst started=%b, required 0", saw);
    end
    mbed_rdy = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_concurrency();
    main_frame(64'h1111_2222_3333_4444);
    main_frame(64'h5555_6666_7777_8888);
    run_burst("conc", 12, 1, 64'h0a0a_0b0b_0c0c_0d0d);
    vectors++;
    if (fill !== 11'(exp_q.size()) || drop_cnt !== 16'(exp_drop) || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL conc_end: fill=%0d drop=%0d ovf=%b, required fill=%0d drop=%0d ovf=1",
               fill, drop_cnt, ovf, exp_q.size(), exp_drop);
    end
  endtask

  task automatic test_divider();
    int          t, t1;
    logic [10:0] prev;
    logic [63:0] d;
    d = 64'h1234_5678_9abc_def0;
    @(negedge sys_clk);
    ch_data  = d;
    tick_sel = 1'b0;
    en       = 1'b1;
    for (int f = 0; f < 2; f++) begin
      t = 0;
      prev = fill;
      while (fill === prev && t < 300) begin
        @(negedge sys_clk);
        t++;
      end
      if (f == 1) en = 1'b0;
      for (int k = 0; k < NCH; k++) exp_q.push_back(mk_word(d, k));
      if (f == 0) begin
        repeat (6) @(negedge sys_clk);
        t1 = 6;
      end else begin
        vectors++;
        if (t + t1 !== 128) begin
          miscompares++;
          $display("FAIL div_spacing: spacing=%0d cycles, required 128", t + t1);
        end
      end
    end
    repeat (6) @(negedge sys_clk);
    prev = fill;
    repeat (300) @(negedge sys_clk);
    vectors++;
    if (fill !== 11'd8 || prev !== 11'd8 || drop_cnt !== 16'(exp_drop)) begin
      miscompares++;
      $display("FAIL div_en_gate: fill=%0d (was %0d) drop=%0d, required fill=8 drop=%0d",
               fill, prev, drop_cnt, exp_drop);
    end
    tick_sel = 1'b1;
    run_burst("div_drain", 8, -1, 64'h0);
  endtask

  task automatic test_overflow();
    int          waited;
    logic [63:0] a;
    a    = 64'h0a04_0a03_0a02_0a01;
    en   = 1'b0;
    s_en = 1'b1;
    main_frame(a);
    vectors++;
    if (s_fill !== 4'd4) begin
      miscompares++;
      $display("FAIL ovf_first: fill=%0d, required 4", s_fill);
    end
    main_frame(64'h0b04_0b03_0b02_0b01);
    vectors++;
    if (s_fill !== 4'd8 || s_full !== 1'b1 || s_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_accept_at_4: fill=%0d full=%b ovf=%b, required 8/1/0", s_fill, s_full, s_ovf);
    end
    s_mbed_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      waited = 0;
      while (s_spi_ena !== 1'b1 && waited < 12) begin
        @(negedge sys_clk);
        waited++;
      end
      vectors++;
      if (s_spi_ena !== 1'b1 || s_spi_data !== mk_word(a, k)) begin
        miscompares++;
        $display("FAIL ovf_pop%0d: ena=%b data=%h, required ena=1 data=%h",
                 k, s_spi_ena, s_spi_data, mk_word(a, k));
      end
      s_spi_fin = 1'b1;
      @(negedge sys_clk);
      s_spi_fin = 1'b0;
    end
    repeat (3) @(negedge sys_clk);
    s_mbed_rdy = 1'b0;
    vectors++;
    if (s_fill !== 4'd6 || s_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_after_burst: fill=%0d busy=%b, required 6/0", s_fill, s_busy);
    end
    main_frame(64'h0c04_0c03_0c02_0c01);
    vectors++;
    if (s_fill !== 4'd6 || s_ovf !== 1'b1 || s_drop_cnt !== 16'd1 || s_full !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_drop: fill=%0d ovf=%b drop=%0d full=%b, required 6/1/1/0",
               s_fill, s_ovf, s_drop_cnt, s_full);
    end
    s_en = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int waited;
    en = 1'b1;
    main_frame(64'h4444_3333_2222_1111);
    @(negedge sys_clk);
    mbed_rdy = 1'b1;
    waited = 0;
    while (spi_ena !== 1'b1 && waited < 12) begin
      @(negedge sys_clk);
      waited++;
    end
    vectors++;
    if (spi_ena !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_start: spi_ena=%b, required 1", spi_ena);
    end
    #2 rstbar = 1'b0;
    #1;
    vectors++;
    if (spi_ena !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_async: ena=%b busy=%b, required 0/0", spi_ena, busy);
    end
    mbed_rdy = 1'b0;
    exp_q.delete();
    exp_drop = 0;
    repeat (3) @(negedge sys_clk);
    rstbar = 1'b1;
    repeat (4) @(negedge sys_clk);
    vectors++;
    if ({fill, ovf, drop_cnt, empty, spi_data, busy, s_ovf, s_drop_cnt} !==
        {11'd0, 1'b0, 16'd0, 1'b1, 18'h0, 1'b0, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL rst_mid_release: fill=%0d ovf=%b drop=%0d empty=%b data=%h busy=%b s_ovf=%b s_drop=%0d, required 0/0/0/1/0/0/0/0",
               fill, ovf, drop_cnt, empty, spi_data, busy, s_ovf, s_drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_ext_tick();
    test_burst();
    test_early_stop();
    test_concurrency();
    test_divider();
    test_overflow();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
